// File: rtl/perf_pkg.sv
// Shared definitions for the retire-stream performance monitor:
// FSM state encoding and parameter defaults.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALT    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int CNT_W_DEF       = 32;
  localparam int WDOG_CYCLES_DEF = 1024;
  localparam int HALT_REPEAT_DEF = 4;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// i_clr is a soft clear with the same effect as i_reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/perf_monitor.sv
// Retire-stream performance monitor with halt (repeated PC) and watchdog detection.
// Stall counter is built only when PERF_STALL_CNT_EN is defined.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for the first retire; nothing counts
//   ST_RUN     | counting cycles/retires, watching for halt and timeout
//   ST_HALT    | HALT_REPEAT retires at one PC seen; counters frozen
//   ST_TIMEOUT | WDOG_CYCLES RUN cycles without a retire; counters frozen
module perf_monitor
  import perf_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF,
  parameter int HALT_REPEAT = HALT_REPEAT_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_insn_vld,
  input  logic             i_mispred,
  input  logic             i_ctrl,
  input  logic [31:0]      i_pc_debug,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_insn_cnt,
  output logic [CNT_W-1:0] o_ctrl_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [1:0]       o_state,
  output logic             o_halted,
  output logic             o_timeout,
  output logic [31:0]      o_last_pc
);

  localparam int REP_W = $clog2(HALT_REPEAT + 1);
  localparam int WDG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LIMIT = REP_W'(HALT_REPEAT);
  localparam logic [WDG_W-1:0] WDG_LOAD  = WDG_W'(WDOG_CYCLES - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [REP_W-1:0] r_repeat;
  logic [REP_W-1:0] w_repeat_nxt;
  logic [WDG_W-1:0] r_wdog;
  logic [31:0]      r_last_pc;
  logic             r_halted;
  logic             r_timeout;
  logic             w_active;
  logic             w_retire;
  logic             w_idle_cyc;
  logic             w_halt_hit;
  logic             w_wdog_hit;

  // The retire that wakes the monitor from IDLE is counted like a RUN cycle.
  assign w_active   = (r_state == ST_RUN) || ((r_state == ST_IDLE) && i_insn_vld);
  assign w_retire   = w_active && i_insn_vld;
  assign w_idle_cyc = (r_state == ST_RUN) && !i_insn_vld;

  assign w_repeat_nxt = ((r_repeat != '0) && (i_pc_debug == r_last_pc)) ?
                        r_repeat + 1'b1 : REP_W'(1);
  assign w_halt_hit   = w_retire && (w_repeat_nxt >= REP_LIMIT);
  // Watchdog is a down-counter reloaded on each retire; terminal count is zero.
  assign w_wdog_hit   = w_idle_cyc && (r_wdog == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_insn_vld) w_state_nxt = w_halt_hit ? ST_HALT : ST_RUN;
      end
      ST_RUN: begin
        if (w_halt_hit)      w_state_nxt = ST_HALT;
        else if (w_wdog_hit) w_state_nxt = ST_TIMEOUT;
      end
      ST_HALT, ST_TIMEOUT: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_state   <= ST_IDLE;
      r_repeat  <= '0;
      r_wdog    <= WDG_LOAD;
      r_last_pc <= '0;
      r_halted  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_retire) begin
        r_repeat  <= w_repeat_nxt;
        r_last_pc <= i_pc_debug;
        r_wdog    <= WDG_LOAD;
      end else if (w_idle_cyc && (r_wdog != '0)) begin
        r_wdog <= r_wdog - 1'b1;
      end
      if (w_halt_hit)      r_halted  <= 1'b1;
      else if (w_wdog_hit) r_timeout <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk(i_clk), .i_reset(i_reset), .i_clr(i_clear),
    .i_inc(w_active), .o_cnt(o_cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_insn_cnt (
    .i_clk(i_clk), .i_reset(i_reset), .i_clr(i_clear),
    .i_inc(w_retire), .o_cnt(o_insn_cnt)
  );

  sat_counter #(.W(CNT_W)) u_ctrl_cnt (
    .i_clk(i_clk), .i_reset(i_reset), .i_clr(i_clear),
    .i_inc(w_retire && i_ctrl), .o_cnt(o_ctrl_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .i_clk(i_clk), .i_reset(i_reset), .i_clr(i_clear),
    .i_inc(w_retire && i_mispred), .o_cnt(o_mispred_cnt)
  );

`ifdef PERF_STALL_CNT_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk(i_clk), .i_reset(i_reset), .i_clr(i_clear),
    .i_inc(w_idle_cyc), .o_cnt(o_stall_cnt)
  );
`else
  assign o_stall_cnt = '0;
`endif

  assign o_state   = r_state;
  assign o_halted  = r_halted;
  assign o_timeout = r_timeout;
  assign o_last_pc = r_last_pc;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: one wide-counter instance for function,
// one 4-bit instance sharing the same stimulus for saturation.
module tb_perf_monitor;

`ifdef PERF_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        vld = 1'b0;
  logic        mis = 1'b0;
  logic        ctl = 1'b0;
  logic [31:0] pc  = '0;

  logic [7:0]  cyc_w, ins_w, ctl_w, mis_w, stl_w;
  logic [1:0]  st_w;
  logic        hlt_w, tmo_w;
  logic [31:0] lpc_w;

  logic [3:0]  cyc_s, ins_s, ctl_s, mis_s, stl_s;
  logic [1:0]  st_s;
  logic        hlt_s, tmo_s;
  logic [31:0] lpc_s;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  perf_monitor #(.CNT_W(8), .WDOG_CYCLES(16), .HALT_REPEAT(4)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_insn_vld(vld),
    .i_mispred(mis), .i_ctrl(ctl), .i_pc_debug(pc),
    .o_cycle_cnt(cyc_w), .o_insn_cnt(ins_w), .o_ctrl_cnt(ctl_w),
    .o_mispred_cnt(mis_w), .o_stall_cnt(stl_w), .o_state(st_w),
    .o_halted(hlt_w), .o_timeout(tmo_w), .o_last_pc(lpc_w)
  );

  perf_monitor #(.CNT_W(4), .WDOG_CYCLES(16), .HALT_REPEAT(4)) u_sat (
    .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_insn_vld(vld),
    .i_mispred(mis), .i_ctrl(ctl), .i_pc_debug(pc),
    .o_cycle_cnt(cyc_s), .o_insn_cnt(ins_s), .o_ctrl_cnt(ctl_s),
    .o_mispred_cnt(mis_s), .o_stall_cnt(stl_s), .o_state(st_s),
    .o_halted(hlt_s), .o_timeout(tmo_s), .o_last_pc(lpc_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later, return to idle inputs.
  task automatic cyc(input logic v, input logic c, input logic m, input logic [31:0] p);
    vld = v; ctl = c; mis = m; pc = p;
    @(posedge clk);
    #1;
    vld = 1'b0; ctl = 1'b0; mis = 1'b0; pc = '0;
  endtask

  initial begin
    // Reset
    cyc(1'b1, 1'b1, 1'b1, 32'hdead);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("rst_state",  st_w,  2'd0);
    check("rst_insn",   ins_w, 8'd0);
    check("rst_cycle",  cyc_w, 8'd0);
    check("rst_halted", hlt_w, 1'b0);
    check("rst_tmo",    tmo_w, 1'b0);
    check("rst_lpc",    lpc_w, 32'h0);
    rst = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 32'h40);
    check("idle_stays", st_w,  2'd0);
    check("idle_cycle", cyc_w, 8'd0);

    // 10 distinct retires: ctrl on #2 and #5, mispred on #7, then a non-retire with flags set
    for (int i = 0; i < 10; i++)
      cyc(1'b1, (i == 2) || (i == 5), (i == 7), 32'h1000 + 32'(4 * i));
    cyc(1'b0, 1'b1, 1'b1, 32'h5555);
    check("run_state",   st_w,  2'd1);
    check("run_insn",    ins_w, 8'd10);
    check("run_ctrl",    ctl_w, 8'd2);
    check("run_mispred", mis_w, 8'd1);
    check("run_cycle",   cyc_w, 8'd11);
    check("run_lpc",     lpc_w, 32'h1024);
    check("run_stall",   stl_w, STALL_EN ? 8'd1 : 8'd0);

    // 10 more retires: 4-bit instance must stick at 15
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 1'b0, 1'b0, 32'h2000 + 32'(4 * i));
    check("sat_insn",  ins_s, 4'd15);
    check("sat_cycle", cyc_s, 4'd15);
    check("wide_insn", ins_w, 8'd20);

    // Repeat count restarts on a different PC, then four in a row halts
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h100);
    cyc(1'b1, 1'b0, 1'b0, 32'h104);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h100);
    check("rep3_state", st_w,  2'd1);
    check("rep3_insn",  ins_w, 8'd27);
    cyc(1'b1, 1'b1, 1'b0, 32'h100);
    check("halt_state",  st_w,  2'd2);
    check("halt_flag",   hlt_w, 1'b1);
    check("halt_insn",   ins_w, 8'd28);
    check("halt_ctrl",   ctl_w, 8'd3);
    check("halt_lpc",    lpc_w, 32'h100);
    check("halt_cycle",  cyc_w, 8'd29);
    for (int i = 0; i < 20; i++) cyc(i[0], 1'b1, 1'b1, 32'h300);
    check("hfrz_state", st_w,  2'd2);
    check("hfrz_insn",  ins_w, 8'd28);
    check("hfrz_cycle", cyc_w, 8'd29);
    check("hfrz_lpc",   lpc_w, 32'h100);
    check("hfrz_tmo",   tmo_w, 1'b0);

    // Soft clear leaves HALT
    clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    clr = 1'b0;
    check("clr_state",  st_w,  2'd0);
    check("clr_insn",   ins_w, 8'd0);
    check("clr_halted", hlt_w, 1'b0);
    check("clr_lpc",    lpc_w, 32'h0);

    // Watchdog: one retire, then 16 RUN cycles without a retire
    cyc(1'b1, 1'b0, 1'b0, 32'h200);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("wd15_state", st_w,  2'd1);
    check("wd15_tmo",   tmo_w, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("tmo_state", st_w,  2'd3);
    check("tmo_flag",  tmo_w, 1'b1);
    check("tmo_stall", stl_w, STALL_EN ? 8'd16 : 8'd0);
    check("tmo_cycle", cyc_w, 8'd17);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 32'h600);
    check("tfrz_state", st_w,  2'd3);
    check("tfrz_insn",  ins_w, 8'd1);
    check("tfrz_lpc",   lpc_w, 32'h200);
    check("tfrz_cycle", cyc_w, 8'd17);

    // Clear wins over a simultaneous retire in RUN
    clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    clr = 1'b0;
    check("clr2_tmo", tmo_w, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h400);
    check("run2_insn", ins_w, 8'd1);
    clr = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 32'h404);
    clr = 1'b0;
    check("clrv_state",   st_w,  2'd0);
    check("clrv_insn",    ins_w, 8'd0);
    check("clrv_ctrl",    ctl_w, 8'd0);
    check("clrv_mispred", mis_w, 8'd0);
    check("clrv_cycle",   cyc_w, 8'd0);
    check("clrv_lpc",     lpc_w, 32'h0);

    // Reset mid-RUN with clear and a retire all asserted
    cyc(1'b1, 1'b0, 1'b0, 32'h500);
    cyc(1'b1, 1'b0, 1'b0, 32'h504);
    check("run3_state", st_w, 2'd1);
    rst = 1'b1;
    clr = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 32'h508);
    check("rrun_state", st_w,  2'd0);
    check("rrun_insn",  ins_w, 8'd0);
    check("rrun_cycle", cyc_w, 8'd0);
    check("rrun_stall", stl_w, 8'd0);
    check("rrun_hlt",   hlt_w, 1'b0);
    check("rrun_tmo",   tmo_w, 1'b0);
    check("rrun_lpc",   lpc_w, 32'h0);
    rst = 1'b0;
    clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
